// File: rtl/nios2_design_ram_dp_if.sv
// nios2_design_ram_dp_if: one Avalon-MM pipelined slave port of the dual-port RAM.
interface nios2_design_ram_dp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int AW         = 8
);
  logic [AW-1:0]           address;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic                    waitrequest;
  modport master (
    output address, byteenable, chipselect, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );
  modport slave (
    input  address, byteenable, chipselect, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/nios2_design_ram_dp.sv
// nios2_design_ram_dp: true dual-port RAM, two Avalon-MM slaves, collision arbitration, write-first forwarding.
// Define NIOS2_RAM_DP_OUTREG_EN to add an output register stage (read latency 2).
module nios2_design_ram_dp #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int AW         = $clog2(DEPTH),
  parameter int INIT_ZERO  = 1
) (
  input logic                  clk,
  input logic                  reset_n,
  nios2_design_ram_dp_if.slave s1,
  nios2_design_ram_dp_if.slave s2
);
  localparam int NB = DATA_WIDTH / 8;
  typedef enum logic [1:0] {RESET, INIT, READY} state_t;
  state_t                state_q;
  logic [AW-1:0]         cnt_q;
  logic                  prio_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         addr [2];
  logic [NB-1:0]         be [2];
  logic [DATA_WIDTH-1:0] wdata [2];
  logic [DATA_WIDTH-1:0] rdata_d [2];
  logic [DATA_WIDTH-1:0] rdata_q [2];
  logic [1:0]            cs, rd, wr, wreq, rreq, stall, wacc, racc, rvalid_q;
  logic                  ready, coll, sweep;
  assign addr  = '{s1.address, s2.address};
  assign be    = '{s1.byteenable, s2.byteenable};
  assign wdata = '{s1.writedata, s2.writedata};
  assign cs    = {s2.chipselect, s1.chipselect};
  assign rd    = {s2.read, s1.read};
  assign wr    = {s2.write, s1.write};
  assign ready = state_q == READY;
  assign sweep = (INIT_ZERO != 0) && !ready && reset_n;
  // a read with write asserted is treated as a write only
  assign wreq  = cs & wr;
  assign rreq  = cs & rd & ~wr;
  assign coll  = ready && (&wreq) && addr[0] == addr[1];
  assign stall = {~ready | (coll & ~prio_q), ~ready | (coll & prio_q)};
  assign wacc  = wreq & ~stall;
  assign racc  = rreq & ~stall;
  assign s1.waitrequest = stall[0];
  assign s2.waitrequest = stall[1];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RESET;
      cnt_q   <= '0;
      prio_q  <= 1'b0;
    end else begin
      if (state_q == RESET) begin
        state_q <= (INIT_ZERO != 0) ? INIT : READY;
        cnt_q   <= (INIT_ZERO != 0) ? AW'(1) : '0;
      end else if (state_q == INIT) begin
        cnt_q <= cnt_q + AW'(1);
        if (&cnt_q) state_q <= READY;
      end
      if (coll) prio_q <= ~prio_q;
    end
  end
  // the sweep starts with word 0 on the first edge after reset release
  always_ff @(posedge clk) begin
    if (sweep) mem[cnt_q] <= '0;
    for (int p = 0; p < 2; p++)
      for (int b = 0; b < NB; b++)
        if (wacc[p] && be[p][b]) mem[addr[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
  end
  always_comb begin
    for (int p = 0; p < 2; p++)
      for (int b = 0; b < NB; b++)
        rdata_d[p][b*8 +: 8] = (wacc[1-p] && addr[1-p] == addr[p] && be[1-p][b])
                               ? wdata[1-p][b*8 +: 8] : mem[addr[p]][b*8 +: 8];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid_q <= '0;
      for (int p = 0; p < 2; p++) rdata_q[p] <= '0;
    end else begin
      rvalid_q <= racc;
      for (int p = 0; p < 2; p++) if (racc[p]) rdata_q[p] <= rdata_d[p];
    end
  end
`ifdef NIOS2_RAM_DP_OUTREG_EN
  logic [DATA_WIDTH-1:0] rdata2_q [2];
  logic [1:0]            rvalid2_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid2_q <= '0;
      for (int p = 0; p < 2; p++) rdata2_q[p] <= '0;
    end else begin
      rvalid2_q <= rvalid_q;
      for (int p = 0; p < 2; p++) if (rvalid_q[p]) rdata2_q[p] <= rdata_q[p];
    end
  end
  assign s1.readdata      = rdata2_q[0];
  assign s2.readdata      = rdata2_q[1];
  assign s1.readdatavalid = rvalid2_q[0];
  assign s2.readdatavalid = rvalid2_q[1];
`else
  assign s1.readdata      = rdata_q[0];
  assign s2.readdata      = rdata_q[1];
  assign s1.readdatavalid = rvalid_q[0];
  assign s2.readdatavalid = rvalid_q[1];
`endif
endmodule

// File: doc/nios2_design_ram_dp.md
# nios2_design_ram_dp

Parametrised true dual-port on-chip RAM with two Avalon-MM pipelined slave ports (s1, s2) on one clock, successor to the fixed 256x32 MMU RAM. Adds configurable width/depth, an optional power-on zeroing sweep, write-collision arbitration with fairness, write-first forwarding between ports, and `readdatavalid` signalling. Sits on the system interconnect beside the CPU, serving MMU/TLB tables or general scratch storage.

## Interface
- `DATA_WIDTH`, 32: word width in bits; multiple of 8, range 8..128.
- `DEPTH`, 256: number of words; power of two, range 16..65536.
- `AW`, $clog2(DEPTH): address width; derived, not overridden.
- `INIT_ZERO`, 1: 1 = zero all words after reset; 0 = no sweep, contents preserved.
- `clk` in 1: single clock; all logic rising-edge.
- `reset_n` in 1: one clock; reset is asynchronous and active-low.
- `s1_address`, `s2_address` in AW: word address.
- `s1_byteenable`, `s2_byteenable` in DATA_WIDTH/8: write byte lanes; ignored on reads.
- `s1_chipselect`, `s2_chipselect` in 1: port select.
- `s1_read`, `s2_read` in 1: read request.
- `s1_write`, `s2_write` in 1: write request.
- `s1_writedata`, `s2_writedata` in DATA_WIDTH: write data.
- `s1_readdata`, `s2_readdata` out DATA_WIDTH: read data, valid when `readdatavalid`.
- `s1_readdatavalid`, `s2_readdatavalid` out 1: one-cycle pulse per accepted read.
- `s1_waitrequest`, `s2_waitrequest` out 1: request not accepted this cycle; master holds all signals.

## Operation
- Request on port p: `chipselect & (read | write)`; `read & write` together = write only, no `readdatavalid`.
- Accepted when request high and `waitrequest` low in same cycle.
- FSM states: RESET (reset_n low), INIT, READY.
  - Reset release -> INIT if `INIT_ZERO`=1, else READY.
  - INIT: counter 0..DEPTH-1, one all-zero full-lane write per cycle; both `waitrequest` = 1; after writing DEPTH-1 -> READY.
  - READY: normal service; stays until reset.
- READY, no collision: both `waitrequest` = 0; both ports service independently.
- Collision: both ports write same address same cycle.
  - Winner = priority holder; loser gets `waitrequest` = 1 for that cycle.
  - Priority register `prio` resets to s1; after collision, priority passes to the loser; non-collision cycles leave `prio` unchanged.
  - Guarantees stalled port is accepted next cycle even if other port repeats same-address write.
- Read/write same address, different ports, same cycle: read returns write-first data, per byte lane: enabled lanes = new writedata, others = old contents.
- Reads different addresses, or reads only: no interaction.
- Reset asserted mid-operation: in-flight reads dropped (no `readdatavalid`), `prio` -> s1, FSM -> RESET; memory not cleared except by subsequent sweep.
- Reset values: `readdata` all 0, `readdatavalid` 0, `waitrequest` 1 (held through INIT).

## Timing
- Read latency L = 1 cycle from acceptance edge to `readdatavalid` (L = 2 with OUTREG, below); one read per port per cycle, fully pipelined.
- `readdata` holds last value while `readdatavalid` low.
- Write visible to a read accepted the following cycle on either port.
- INIT duration: exactly DEPTH cycles after first `clk` edge with reset_n high; `waitrequest` falls on cycle DEPTH+1.
- Collision stall: exactly 1 cycle per collision for the loser.

## Configuration
- `NIOS2_RAM_DP_OUTREG_EN` defined: extra register on `readdata`/`readdatavalid` of both ports; L = 2; forwarding semantics unchanged (data as of acceptance cycle).
- Undefined: L = 1, unregistered array output path.

## Test plan
- Reset, `INIT_ZERO`=1, DEPTH=256 -> `waitrequest` high 256 cycles; then read addr 0x00 and 0xFF -> `readdata` 0x00000000 after L cycles.
- s1 write 0xDEADBEEF @0x10, be=0xF; next cycle s2 read @0x10 -> s2 `readdatavalid` at L, data 0xDEADBEEF.
- s1 and s2 write @0x20 same cycle (0x11111111 / 0x22222222), s2 holds -> s2 stalled 1 cycle, final read 0x22222222; repeat same collision -> s1 stalled (priority swapped).
- Word @0x30 = 0xAABBCCDD; s1 write 0x00000011 be=0x1 while s2 reads @0x30 same cycle -> s2 gets 0xAABBCC11.
- Back-to-back s1 reads @0..7 every cycle -> 8 consecutive `readdatavalid` pulses, data in order, no `waitrequest`.
- Assert reset_n low with 2 reads in flight -> no `readdatavalid`, outputs at reset values, INIT restarts.
